fft_io_ctrl: RTL and testbench
==============================

FFT_IO_CTRL -- requirements
Module: fft_io_ctrl

Interface
REQ-001 The block SHALL have parameter IWL, default 32, meaning the complex word width ({re[IWL/2-1:0], im[IWL/2-1:0]}).
REQ-002 The block SHALL have parameter AWL, default 5, meaning the RAM address width; frame length is N = 2**AWL.
REQ-003 The block SHALL have parameter BITREV, default 1, meaning readout addresses are bit-reversed when 1 and linear when 0.
REQ-004 CLK  input  1  clock; all logic SHALL run on the rising edge.
REQ-005 RST  input  1  reset; synchronous, active-low.
REQ-006 EN  input  1  global enable; while low, all state and outputs SHALL hold and s_READY SHALL be 0.
REQ-007 s_DATA  input  IWL  input sample; s_VALID  input  1; s_READY  output  1 (input stream handshake).
REQ-008 m_DATA  output  IWL  result sample; m_VALID  output  1; m_READY  input  1; m_LAST  output  1, high on the N-th result.
REQ-009 o_A_DATA  output  IWL; o_A_ADDR  output  AWL; o_RAM_Wr  output  1 (FFT RAM write port).
REQ-010 o_B_ADDR  output  AWL  FFT RAM read address; i_B_DATA  input  IWL  read data, valid exactly 1 cycle after the address.
REQ-011 o_START  output  1  FFT start pulse; i_RAM_BLOCK  input  1  high while the FFT core owns the RAM.
REQ-012 o_BUSY  output  1  high in every state except LOAD with zero samples accepted.

Function
REQ-013 The FSM SHALL have states LOAD, KICK, WAIT, DRAIN.
REQ-014 In LOAD, s_READY SHALL be 1, and each s_VALID&s_READY cycle SHALL drive o_RAM_Wr=1, o_A_ADDR=load count, o_A_DATA=s_DATA in that same cycle, then increment the load count.
REQ-015 When the N-th sample is accepted, the next state SHALL be KICK and the load count SHALL wrap to 0.
REQ-016 KICK SHALL last exactly one cycle, with o_START=1 for that cycle only, and SHALL go to WAIT.
REQ-017 WAIT SHALL set a seen flag on the first cycle i_RAM_BLOCK=1, and SHALL go to DRAIN on the first cycle with i_RAM_BLOCK=0 and the seen flag set.
REQ-018 In DRAIN, the read index k SHALL run 0..N-1; o_B_ADDR SHALL be bitrev(k) when BITREV=1, else k.
REQ-019 A read SHALL be issued only when the 2-entry output skid buffer has room for data already in flight; no result SHALL be dropped or duplicated under any m_READY pattern.
REQ-020 m_DATA/m_VALID SHALL come from the skid head; a transfer SHALL occur on m_VALID&m_READY; m_DATA SHALL hold stable while m_VALID=1 and m_READY=0.
REQ-021 m_LAST SHALL be 1 exactly on the transfer of index N-1; after that transfer the FSM SHALL return to LOAD.
REQ-022 Minimum latency SHALL be 2 cycles from DRAIN entry to first m_VALID; with m_READY held high, results SHALL stream at one per cycle.
REQ-023 o_RAM_Wr SHALL be 0 outside LOAD; s_READY SHALL be 0 outside LOAD; o_START SHALL be 0 outside KICK.
REQ-024 With EN=0 during any state, counters, the seen flag and the skid buffer SHALL hold, and no handshake SHALL complete.

Reset
REQ-025 With RST=0 at a clock edge, the block SHALL enter LOAD with counters, seen flag and skid cleared, and with all outputs 0 except s_READY, which SHALL be 0 during reset and 1 from the first cycle after release.
REQ-026 Reset in the middle of any state SHALL abandon the frame; no partial output SHALL be emitted after release.

Structure
REQ-027 The FSM state encoding and a bit-reverse function of width AWL SHALL be placed in the shared package fft_pkg.
REQ-028 The output skid buffer SHALL be the sub-module fft_skid2 (2-entry, valid/ready, width IWL).

Verification
REQ-029 Reset/idle: hold RST=0 for 3 cycles, then release -> all outputs 0 during reset; s_READY=1 and o_BUSY=0 on the first cycle after release.
REQ-030 Load: AWL=5, samples k=0..31 with s_VALID always 1 -> 32 writes with o_A_ADDR=k, o_A_DATA=k, then a single-cycle o_START.
REQ-031 Block handshake: i_RAM_BLOCK rises 3 cycles after o_START and stays high 100 cycles -> no o_B_ADDR activity until the cycle after it falls.
REQ-032 Bit-reverse drain: RAM model returns data equal to its address, BITREV=1, m_READY=1 -> m_DATA sequence 0,16,8,24,...,31, with m_LAST on the 32nd word.
REQ-033 Backpressure: m_READY driven by a random 50% pattern -> all 32 words delivered exactly once, in order, and m_DATA stable while stalled.
REQ-034 Interruptions: EN=0 for 5 cycles in each state, and RST asserted mid-DRAIN -> state is frozen while EN=0; after reset, LOAD is entered with no residual m_VALID.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT I/O controller: FSM encoding and address bit-reversal.
package fft_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    KICK  = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int MAX_AWL = 16;

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [MAX_AWL-1:0] bitrev(input logic [MAX_AWL-1:0] v, input int w);
    logic [MAX_AWL-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_AWL; i++) begin
      if (i < w) r[i] = v[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_skid2.sv
// Two-entry valid/ready output buffer; EN low freezes contents and blocks both push and pop.
module fft_skid2 #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         EN,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  output logic [W-1:0] out_dat,
  input  logic         out_rdy,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;
  logic         push;
  logic         pop;

  assign push    = EN && in_vld;
  assign pop     = EN && out_vld && out_rdy;
  assign out_vld = (cnt != 2'd0);
  assign out_dat = out_vld ? mem[rd_ptr] : '0;
  assign count   = cnt;

  // The producer only pushes when it has reserved room, so push-while-full never happens.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_dat;
        wr_ptr      <= !wr_ptr;
      end
      if (pop) rd_ptr <= !rd_ptr;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/fft_io_ctrl.sv
// Frame loader/unloader around an FFT core: fills the RAM with N samples, kicks the core,
// waits for it to release the RAM, then streams the results out in (optionally) bit-reversed order.
module fft_io_ctrl
  import fft_pkg::*;
#(
  parameter int IWL    = 32,
  parameter int AWL    = 5,
  parameter int BITREV = 1
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           EN,
  input  logic [IWL-1:0] s_DATA,
  input  logic           s_VALID,
  output logic           s_READY,
  output logic [IWL-1:0] m_DATA,
  output logic           m_VALID,
  input  logic           m_READY,
  output logic           m_LAST,
  output logic [IWL-1:0] o_A_DATA,
  output logic [AWL-1:0] o_A_ADDR,
  output logic           o_RAM_Wr,
  output logic [AWL-1:0] o_B_ADDR,
  input  logic [IWL-1:0] i_B_DATA,
  output logic           o_START,
  input  logic           i_RAM_BLOCK,
  output logic           o_BUSY
);

  localparam logic [AWL-1:0] LAST_IDX = '1;

  state_t         state;
  state_t         state_nx;
  logic [AWL-1:0] load_cnt;
  logic [AWL-1:0] out_cnt;
  logic [AWL:0]   rd_cnt;
  logic           seen;
  logic           pend;
  logic           held_vld;
  logic [IWL-1:0] held_dat;
  logic [IWL-1:0] sk_in;
  logic [1:0]     sk_cnt;
  logic [2:0]     occ;
  logic           wr;
  logic           pop;
  logic           rd_go;
  logic           drain_done;

  assign sk_in = held_vld ? held_dat : i_B_DATA;

  fft_skid2 #(.W(IWL)) u_skid (
    .CLK     (CLK),
    .RST     (RST),
    .EN      (EN),
    .in_vld  (pend),
    .in_dat  (sk_in),
    .out_vld (m_VALID),
    .out_dat (m_DATA),
    .out_rdy (m_READY),
    .count   (sk_cnt)
  );

  always_ff @(posedge CLK) begin
    if (!RST)    state <= LOAD;
    else if (EN) state <= state_nx;
  end

  always_comb begin
    s_READY    = RST && EN && (state == LOAD);
    wr         = s_READY && s_VALID;
    o_RAM_Wr   = wr;
    o_A_ADDR   = load_cnt;
    o_A_DATA   = wr ? s_DATA : '0;
    o_START    = (state == KICK);
    o_BUSY     = !((state == LOAD) && (load_cnt == '0));
    pop        = EN && m_VALID && m_READY;
    // Occupancy the skid will have after this edge; a read issued now lands one cycle later.
    occ        = {1'b0, sk_cnt} + {2'b0, pend} - {2'b0, pop};
    rd_go      = EN && (state == DRAIN) && !rd_cnt[AWL] && (occ < 3'd2);
    drain_done = pop && (out_cnt == LAST_IDX);
    m_LAST     = m_VALID && (state == DRAIN) && (out_cnt == LAST_IDX);
    if (state != DRAIN)  o_B_ADDR = '0;
    else if (BITREV != 0) o_B_ADDR = AWL'(bitrev(MAX_AWL'(rd_cnt[AWL-1:0]), AWL));
    else                 o_B_ADDR = rd_cnt[AWL-1:0];

    state_nx = state;
    case (state)
      LOAD:    if (wr && (load_cnt == LAST_IDX)) state_nx = KICK;
      KICK:    state_nx = WAIT;
      WAIT:    if (!i_RAM_BLOCK && seen) state_nx = DRAIN;
      DRAIN:   if (drain_done) state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  // RAM read data is only valid for one cycle, so a read in flight when EN drops is parked in held_dat.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      load_cnt <= '0;
      out_cnt  <= '0;
      rd_cnt   <= '0;
      seen     <= 1'b0;
      pend     <= 1'b0;
      held_vld <= 1'b0;
      held_dat <= '0;
    end else if (EN) begin
      if (wr) load_cnt <= load_cnt + 1'b1;
      if (state == WAIT) seen <= (state_nx == DRAIN) ? 1'b0 : (seen || i_RAM_BLOCK);
      if (drain_done)  rd_cnt <= '0;
      else if (rd_go)  rd_cnt <= rd_cnt + 1'b1;
      if (pop) out_cnt <= out_cnt + 1'b1;
      pend     <= rd_go;
      held_vld <= 1'b0;
    end else if (pend && !held_vld) begin
      held_dat <= i_B_DATA;
      held_vld <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_io_ctrl.sv
// Randomized frame-level bench for fft_io_ctrl with a transaction model and per-cycle compare.
module tb_fft_io_ctrl;

  localparam int IWL = 32;
  localparam int AWL = 5;
  localparam int N   = 32;

  logic           CLK = 1'b0;
  logic           RST, EN, s_VALID, s_READY, m_VALID, m_READY, m_LAST;
  logic           o_RAM_Wr, o_START, i_RAM_BLOCK, o_BUSY;
  logic [IWL-1:0] s_DATA, m_DATA, o_A_DATA, i_B_DATA;
  logic [AWL-1:0] o_A_ADDR, o_B_ADDR;

  always #5 CLK = ~CLK;

  fft_io_ctrl #(.IWL(IWL), .AWL(AWL), .BITREV(1)) dut (
    .CLK(CLK), .RST(RST), .EN(EN),
    .s_DATA(s_DATA), .s_VALID(s_VALID), .s_READY(s_READY),
    .m_DATA(m_DATA), .m_VALID(m_VALID), .m_READY(m_READY), .m_LAST(m_LAST),
    .o_A_DATA(o_A_DATA), .o_A_ADDR(o_A_ADDR), .o_RAM_Wr(o_RAM_Wr),
    .o_B_ADDR(o_B_ADDR), .i_B_DATA(i_B_DATA),
    .o_START(o_START), .i_RAM_BLOCK(i_RAM_BLOCK), .o_BUSY(o_BUSY)
  );

  // FFT RAM stand-in: write port A, read port B with one cycle of latency.
  logic [IWL-1:0] ram [N];
  always @(posedge CLK) begin
    if (o_RAM_Wr) ram[o_A_ADDR] <= o_A_DATA;
    i_B_DATA <= ram[o_B_ADDR];
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int tb_rev(input int v);
    int r = 0;
    for (int i = 0; i < AWL; i++) r = r * 2 + (v >> i) % 2;
    return r;
  endfunction

  // Transaction model: phase 0 load, 1 kick, 2 wait for RAM release, 3 drain.
  int             phase = 0, nload = 0, ntx = 0, frames_done = 0, frame_no = 0;
  int             drain_cyc = 0, kick_cyc = -1000, first_tx = 0, last_tx = 0;
  logic           seen_m = 1'b0, firstv = 1'b0;
  logic [IWL-1:0] frame [N];
  logic [IWL-1:0] expq [$];
  logic [IWL-1:0] got1 [$];

  logic           prev_rst = 1'b0, prev_en = 1'b0, prev_vld = 1'b0, prev_rdy = 1'b0;
  logic           prev_start = 1'b0, prev_busy = 1'b0;
  logic [IWL-1:0] prev_dat = '0;
  logic [AWL-1:0] prev_baddr = '0;
  int             prev_phase = 0;

  always @(negedge CLK) begin
    int cur_phase;
    cur_phase = phase;
    if (!RST) begin
      if (!prev_rst) begin
        chk("rst_s_ready", s_READY, 0);   chk("rst_m_valid", m_VALID, 0);
        chk("rst_m_data", m_DATA, 0);     chk("rst_m_last", m_LAST, 0);
        chk("rst_ram_wr", o_RAM_Wr, 0);   chk("rst_start", o_START, 0);
        chk("rst_busy", o_BUSY, 0);       chk("rst_a_data", o_A_DATA, 0);
        chk("rst_a_addr", o_A_ADDR, 0);   chk("rst_b_addr", o_B_ADDR, 0);
      end else begin
        chk("rst_s_ready_first", s_READY, 0);
      end
      phase = 0; nload = 0; ntx = 0; seen_m = 1'b0; firstv = 1'b0;
      expq.delete();
    end else begin
      chk("s_ready", s_READY, EN && phase == 0);
      chk("start", o_START, phase == 1);
      chk("ram_wr", o_RAM_Wr, EN && phase == 0 && s_VALID);
      chk("busy", o_BUSY, !(phase == 0 && nload == 0));
      if (phase != 3) begin
        chk("idle_m_valid", m_VALID, 0);
        chk("idle_b_addr", o_B_ADDR, 0);
        chk("idle_m_last", m_LAST, 0);
      end else begin
        chk("m_last", m_LAST, m_VALID && ntx == N - 1);
        if (prev_rst && prev_phase == 3 && prev_vld && !(prev_rdy && prev_en)) begin
          chk("stall_valid", m_VALID, 1);
          chk("stall_data", m_DATA, prev_dat);
        end
      end
      if (!EN && !prev_en && prev_rst) begin
        chk("hold_m_valid", m_VALID, prev_vld);
        chk("hold_m_data", m_DATA, prev_dat);
        chk("hold_start", o_START, prev_start);
        chk("hold_busy", o_BUSY, prev_busy);
        chk("hold_b_addr", o_B_ADDR, prev_baddr);
      end
      if (EN) begin
        case (phase)
          0: if (s_VALID) begin
            chk("a_addr", o_A_ADDR, nload);
            chk("a_data", o_A_DATA, s_DATA);
            frame[nload] = s_DATA;
            nload++;
            if (nload == N) begin
              nload = 0; phase = 1;
              expq.delete();
              for (int k = 0; k < N; k++) expq.push_back(frame[tb_rev(k)]);
            end
          end
          1: begin kick_cyc = cyc; phase = 2; end
          2: if (i_RAM_BLOCK) seen_m = 1'b1;
             else if (seen_m) begin seen_m = 1'b0; phase = 3; drain_cyc = cyc + 1; firstv = 1'b1; end
          default: begin
            if (m_VALID && firstv) begin
              firstv = 1'b0;
              if (frame_no == 1) chk("first_latency", cyc - drain_cyc, 2);
            end
            if (m_VALID && m_READY) begin
              if (expq.size() == 0) chk("extra_output", 1, 0);
              else chk("m_data", m_DATA, expq.pop_front());
              if (frame_no == 1) begin
                got1.push_back(m_DATA);
                if (ntx == 0) first_tx = cyc;
                if (ntx == N - 1) last_tx = cyc;
              end
              ntx++;
              if (ntx == N) begin ntx = 0; phase = 0; frames_done++; end
            end
          end
        endcase
      end
    end
    prev_rst = RST; prev_en = EN; prev_vld = m_VALID; prev_rdy = m_READY;
    prev_dat = m_DATA; prev_start = o_START; prev_busy = o_BUSY; prev_baddr = o_B_ADDR;
    prev_phase = cur_phase;
    cyc++;
  end

  int       blk_len    = 100;
  int       pause_left = 0;
  logic [3:0] paused   = '0;

  task automatic drive(input int f);
    @(posedge CLK); #1;
    if (f == 4 && pause_left == 0 && !paused[phase] && (phase != 0 || nload >= 10)) begin
      paused[phase] = 1'b1;
      pause_left = 5;
    end
    if (pause_left > 0) begin EN = 1'b0; pause_left--; end
    else EN = 1'b1;
    i_RAM_BLOCK = (cyc >= kick_cyc + 3) && (cyc < kick_cyc + 3 + blk_len);
    m_READY = (f == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    s_VALID = (f == 1) ? 1'b1 : ($urandom_range(0, 9) < 7);
    s_DATA  = (f == 1) ? IWL'(nload) : $urandom;
  endtask

  initial begin
    RST = 1'b0; EN = 1'b1; s_VALID = 1'b0; s_DATA = '0; m_READY = 1'b1; i_RAM_BLOCK = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    for (int f = 1; f <= 6; f++) begin
      int target;
      int budget;
      frame_no = f;
      blk_len  = (f == 1) ? 100 : 10;
      target   = frames_done + 1;
      budget   = 0;
      if (f == 5) begin
        while (!(phase == 3 && ntx >= 5) && budget < 3000) begin drive(f); budget++; end
        chk("reach_mid_drain", budget < 3000, 1);
        @(posedge CLK); #1;
        RST = 1'b0; EN = 1'b1;
        repeat (2) begin @(posedge CLK); #1; end
        RST = 1'b1;
        repeat (8) drive(f);
      end else begin
        while (frames_done < target && budget < 3000) begin drive(f); budget++; end
        chk("frame_timeout", budget < 3000, 1);
      end
    end
    chk("frames_done", frames_done, 5);
    chk("frame1_count", got1.size(), N);
    if (got1.size() == N) begin
      chk("pin_out0", got1[0], 0);
      chk("pin_out1", got1[1], 16);
      chk("pin_out2", got1[2], 8);
      chk("pin_out3", got1[3], 24);
      chk("pin_out31", got1[31], 31);
      chk("stream_rate", last_tx - first_tx, N - 1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
